// File: rtl/simon_key_schedule_pkg.sv
// Shared Simon96/96 constants: word geometry, round-constant sequences,
// the FSM state type and a helper to pick one z bit.
package simon_key_schedule_pkg;

  localparam int N = 48;
  localparam int M = 2;
  localparam int T = 52;

  // Leftmost character of each sequence is z[0], stored in bit 61.
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  // c = 2^N - 4; the key step folds it in as ~x ^ 3.
  localparam logic [N-1:0] C = {{(N-2){1'b1}}, 2'b00};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic z_bit(input logic [61:0] seq, input logic [5:0] i);
    return seq[6'd61 - i];
  endfunction

endpackage

// File: rtl/simon_key_schedule_if.sv
// Start/key load and round-key stream between the key schedule and its user.
interface simon_key_schedule_if;
  import simon_key_schedule_pkg::*;

  logic           start;
  logic [M*N-1:0] key;
  logic [N-1:0]   rk;
  logic [5:0]     rk_idx;
  logic           rk_valid;
  logic           rk_ready;
  logic           busy;
  logic           done;

  modport master (
    output start, key, rk_ready,
    input  rk, rk_idx, rk_valid, busy, done
  );

  modport slave (
    input  start, key, rk_ready,
    output rk, rk_idx, rk_valid, busy, done
  );

endinterface

// File: rtl/simon_key_schedule_step.sv
// One Simon key-expansion step for M=2: next = c ^ z ^ ka ^ (ROR3(kb) ^ ROR4(kb)).
module simon_key_step
  import simon_key_schedule_pkg::*;
(
  input  logic [N-1:0] ka,
  input  logic [N-1:0] kb,
  input  logic         zbit,
  output logic [N-1:0] next
);

  logic [N-1:0] tmp3;
  logic [N-1:0] tmp;

  // Rotations are pure rewiring; only the XORs cost logic.
  always_comb begin
    tmp3 = {kb[2:0], kb[N-1:3]};
    tmp  = tmp3 ^ {tmp3[0], tmp3[N-1:1]};
    next = ~ka ^ tmp ^ {{(N-1){1'b0}}, zbit} ^ {{(N-2){1'b0}}, 2'b11};
  end

endmodule

// File: rtl/simon_key_schedule.sv
// Sequential Simon96/96 key expansion: loads a master key and streams
// round keys k0..k(T-1) over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; done pulses here after a stream
// RUN   | rk = ka is offered; each transfer advances the key pair
module simon_key_schedule
  import simon_key_schedule_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  simon_key_schedule_if.slave bus
);

  state_t       state;
  state_t       state_nx;
  logic [N-1:0] ka;
  logic [N-1:0] kb;
  logic [N-1:0] kb_step;
  logic [5:0]   idx;
  logic [5:0]   zi;
  logic         done_q;
  logic         load;
  logic         xfer;
  logic         last;
  logic         zbit;

  assign xfer = (state == RUN) && bus.rk_ready;
  assign last = (idx == 6'(T - 1));
  assign zbit = z_bit(Z2, zi);

  simon_key_step u_step (
    .ka   (ka),
    .kb   (kb),
    .zbit (zbit),
    .next (kb_step)
  );

  // Next-state decode; start is only looked at while idle.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = RUN;
          load     = 1'b1;
        end
      end
      RUN: begin
        if (xfer && last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, key pair and counters; everything holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ka     <= '0;
      kb     <= '0;
      idx    <= '0;
      zi     <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= xfer && last;
      if (load) begin
        ka  <= bus.key[N-1:0];
        kb  <= bus.key[2*N-1:N];
        idx <= '0;
        zi  <= '0;
      end else if (xfer && !last) begin
        ka  <= kb;
        kb  <= kb_step;
        idx <= idx + 6'd1;
        zi  <= (zi == 6'd61) ? 6'd0 : zi + 6'd1;
      end
    end
  end

  assign bus.rk       = ka;
  assign bus.rk_idx   = idx;
  assign bus.rk_valid = (state == RUN);
  assign bus.busy     = (state == RUN);
  assign bus.done     = done_q;

endmodule
